// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry adder operand feeder: the credit counter
// width, the operand-pair record and a constant-evaluable clog2 helper.
package rca_pkg;

    localparam int unsigned CREDIT_WIDTH    = 8;
    localparam int unsigned PAIR_DATA_WIDTH = 32;

    typedef struct packed {
        logic [PAIR_DATA_WIDTH-1:0] a;
        logic [PAIR_DATA_WIDTH-1:0] b;
    } operand_pair_t;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rca_pair_fifo.sv
// Synchronous operand-pair FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart without a separate counter.
module rca_pair_fifo
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  level
);

    localparam int unsigned PTR_W = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                      (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
    assign level    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[PTR_W-2:0]];

    // Pointer advance; pushes into a full FIFO and pops from an empty one are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PTR_W-2:0]] <= push_data;
        end
    end

endmodule

// File: rtl/rca_operand_feeder.sv
// Operand feeder for the registered ripple-carry adder: buffers operand pairs,
// issues one pair per cycle under a credit limit and flags when the adder's
// registered result for an issued pair is present.
// Optional statistics counters are enabled by defining RCA_FEEDER_STATS_EN.
module rca_operand_feeder
    import rca_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ADD_LATENCY = 1,
    parameter int unsigned MAX_CREDITS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_a,
    input  logic [DATA_WIDTH-1:0]        in_b,
    output logic [DATA_WIDTH-1:0]        out_sum_a,
    output logic [DATA_WIDTH-1:0]        out_sum_b,
    output logic                         out_issue,
    output logic                         res_valid,
    input  logic                         res_ack,
    output logic [CREDIT_WIDTH-1:0]      credits,
    output logic [clog2(FIFO_DEPTH):0]   fifo_level
`ifdef RCA_FEEDER_STATS_EN
    ,
    output logic [31:0]                  stat_issued,
    output logic [31:0]                  stat_stall
`endif
);

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(MAX_CREDITS);

    logic                      push;
    logic                      issue;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [2*DATA_WIDTH-1:0]   head;
    logic [ADD_LATENCY-1:0]    lat_pipe;

    // Full is exactly fifo_level == FIFO_DEPTH, and both come from registered pointers,
    // so there is no ready-through-pop path.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign issue    = !fifo_empty && (credits != '0);

    rca_pair_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({in_a, in_b}),
        .pop       (issue),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Operand registers toward the adder plus the one-cycle issue strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_sum_a <= '0;
            out_sum_b <= '0;
            out_issue <= 1'b0;
        end else begin
            out_issue <= issue;
            if (issue) begin
                out_sum_a <= head[2*DATA_WIDTH-1:DATA_WIDTH];
                out_sum_b <= head[DATA_WIDTH-1:0];
            end
        end
    end

    // Delay line matching the adder pipeline; reset drops any in-flight results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_pipe <= '0;
        end else begin
            lat_pipe[0] <= out_issue;
            for (int i = 1; i < ADD_LATENCY; i++) begin
                lat_pipe[i] <= lat_pipe[i-1];
            end
        end
    end

    assign res_valid = lat_pipe[ADD_LATENCY-1];

    // Credit counter: issue takes one, ack returns one, ack beyond the limit is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits <= CREDIT_MAX;
        end else if (issue && !res_ack) begin
            credits <= credits - CREDIT_WIDTH'(1);
        end else if (!issue && res_ack && (credits != CREDIT_MAX)) begin
            credits <= credits + CREDIT_WIDTH'(1);
        end
    end

`ifdef RCA_FEEDER_STATS_EN
    // Saturating issue and credit-stall counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue && (stat_issued != '1)) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (!fifo_empty && (credits == '0) && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rca_operand_feeder.sv
// Self-checking bench for rca_operand_feeder: a queue-based reference model is
// compared with the DUT every cycle, plus directed literal expectations.
// Statistics ports are connected and checked when RCA_FEEDER_STATS_EN is defined.
module tb_rca_operand_feeder;
    import rca_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 1;
    localparam int unsigned MAXC  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [DW-1:0] out_sum_a;
    logic [DW-1:0] out_sum_b;
    logic          out_issue;
    logic          res_valid;
    logic          res_ack;
    logic [7:0]    credits;
    logic [2:0]    fifo_level;
`ifdef RCA_FEEDER_STATS_EN
    logic [31:0]   stat_issued;
    logic [31:0]   stat_stall;
`endif

    always #5 clk = ~clk;

    rca_operand_feeder #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .ADD_LATENCY (LAT),
        .MAX_CREDITS (MAXC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_sum_a  (out_sum_a),
        .out_sum_b  (out_sum_b),
        .out_issue  (out_issue),
        .res_valid  (res_valid),
        .res_ack    (res_ack),
        .credits    (credits),
        .fifo_level (fifo_level)
`ifdef RCA_FEEDER_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, credits as an integer, results as due cycles.
    operand_pair_t mq[$];
    int            m_credits = 0;
    int            m_cyc = 0;
    bit            m_issue = 1'b0;
    bit            m_resv = 1'b0;
    logic [DW-1:0] m_a = '0;
    logic [DW-1:0] m_b = '0;
    bit            due[int];
    int            m_stat_issued = 0;
    int            m_stat_stall = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            due.delete();
            m_credits     = MAXC;
            m_cyc         = 0;
            m_issue       = 1'b0;
            m_resv        = 1'b0;
            m_a           = '0;
            m_b           = '0;
            m_stat_issued = 0;
            m_stat_stall  = 0;
        end else begin
            bit            iss;
            bit            psh;
            operand_pair_t p;
            iss = (mq.size() > 0) && (m_credits > 0);
            psh = in_valid && (mq.size() < DEPTH);
            if ((mq.size() > 0) && (m_credits == 0)) m_stat_stall++;
            m_cyc++;
            if (iss) begin
                p = mq.pop_front();
                m_a = p.a;
                m_b = p.b;
                m_credits--;
                due[m_cyc + LAT] = 1'b1;
                m_stat_issued++;
            end
            if (psh) mq.push_back('{a: in_a, b: in_b});
            if (res_ack) m_credits++;
            if (m_credits > MAXC) m_credits = MAXC;
            m_issue = iss;
            m_resv  = due.exists(m_cyc);
            if (m_resv) due.delete(m_cyc);
        end
    end

    // Every-cycle comparison, 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        check("m_in_ready",   in_ready,   (mq.size() != DEPTH));
        check("m_fifo_level", fifo_level, mq.size());
        check("m_credits",    credits,    m_credits);
        check("m_out_issue",  out_issue,  m_issue);
        check("m_res_valid",  res_valid,  m_resv);
        check("m_out_sum_a",  out_sum_a,  m_a);
        check("m_out_sum_b",  out_sum_b,  m_b);
`ifdef RCA_FEEDER_STATS_EN
        check("m_stat_issued", stat_issued, m_stat_issued);
        check("m_stat_stall",  stat_stall,  m_stat_stall);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int issues;
        in_valid = 1'b0;
        res_ack  = 1'b0;
        in_a     = '0;
        in_b     = '0;

        // Reset values
        #1 reset = 1'b1;
        #1;
        check("rst_out_issue", out_issue, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_credits",   credits, 4);
        check("rst_level",     fifo_level, 0);
        check("rst_in_ready",  in_ready, 1);
        check("rst_sum_a",     out_sum_a, 0);
`ifdef RCA_FEEDER_STATS_EN
        check("rst_stat_issued", stat_issued, 0);
        check("rst_stat_stall",  stat_stall, 0);
`endif
        tick();
        tick();
        reset = 1'b0;

        // Single pair: issue two cycles after the push, result one cycle later
        in_valid = 1'b1; in_a = 5; in_b = 7;
        tick();
        in_valid = 1'b0;
        check("t1_level", fifo_level, 1);
        check("t1_no_issue_yet", out_issue, 0);
        tick();
        check("t1_issue", out_issue, 1);
        check("t1_sum_a", out_sum_a, 5);
        check("t1_sum_b", out_sum_b, 7);
        check("t1_credits", credits, 3);
        tick();
        check("t1_res_valid", res_valid, 1);
        check("t1_issue_pulse", out_issue, 0);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        check("t1_credit_back", credits, 4);

        // Six back-to-back pushes with no acks: four issues then stall
        issues = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_a = 100 + i; in_b = 200 + i;
            tick();
            issues += int'(out_issue);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            issues += int'(out_issue);
        end
        check("t2_issue_count", issues, 4);
        check("t2_credits", credits, 0);
        check("t2_level", fifo_level, 2);
        check("t2_ready", in_ready, 1);
        check("t2_last_a", out_sum_a, 103);
        for (int i = 6; i < 8; i++) begin
            in_valid = 1'b1; in_a = 100 + i; in_b = 200 + i;
            tick();
        end
        check("t3_full_level", fifo_level, 4);
        check("t3_not_ready", in_ready, 0);
        in_a = 999; in_b = 999;
        tick();
        in_valid = 1'b0;
        check("t3_rejected", fifo_level, 4);

        // Acks drain the FIFO at a steady credit, then credits saturate
        res_ack = 1'b1;
        repeat (10) tick();
        res_ack = 1'b0;
        check("t4_credits_sat", credits, 4);
        check("t4_level", fifo_level, 0);
        check("t4_last_a", out_sum_a, 107);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        check("t4_ack_at_max", credits, 4);

        // Issue and ack in the same cycle at credits = 2
        in_valid = 1'b1; in_a = 1; in_b = 2;
        tick();
        in_a = 3; in_b = 4;
        tick();
        in_valid = 1'b0;
        tick();
        check("t5_credits_two", credits, 2);
        in_valid = 1'b1; in_a = 9; in_b = 10;
        tick();
        in_valid = 1'b0;
        res_ack  = 1'b1;
        tick();
        res_ack = 1'b0;
        check("t5_credits_kept", credits, 2);
        check("t5_issue", out_issue, 1);
        check("t5_sum_a", out_sum_a, 9);

        // Reset with three entries queued and one pair in flight
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_a = 50 + i; in_b = 60 + i;
            tick();
        end
        in_valid = 1'b0;
        res_ack  = 1'b1;
        tick();
        res_ack = 1'b0;
        tick();
        check("t6_level", fifo_level, 3);
        check("t6_issue", out_issue, 1);
        check("t6_sum_a", out_sum_a, 52);
        #1 reset = 1'b1;
        #1;
        check("t6_rst_issue", out_issue, 0);
        check("t6_rst_sum_a", out_sum_a, 0);
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_credits", credits, 4);
        check("t6_rst_ready", in_ready, 1);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_no_res_valid", res_valid, 0);
        end

        // Randomized traffic against the model
        repeat (400) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_a     = $urandom;
            in_b     = $urandom;
            res_ack  = ($urandom_range(0, 9) < 4);
            tick();
        end
        in_valid = 1'b0;
        res_ack  = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
